// File: rtl/shift_pkg.sv
// shift_pkg: op and state encodings plus default widths for the shift sequencer.
package shift_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_AMTW = 4;
  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_LSL = 2'b01;
  localparam logic [1:0] OP_LSR = 2'b10;
  localparam logic [1:0] OP_ASR = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/shift_step.sv
// shift_step: one single-bit shift of data by op, returning the shifted word and the bit pushed out.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             bit_o
);
  always_comb begin
    data_o = op_i == OP_LSL ? {data_i[WIDTH-2:0], 1'b0} :
             op_i == OP_LSR ? {1'b0, data_i[WIDTH-1:1]} :
             op_i == OP_ASR ? {data_i[WIDTH-1], data_i[WIDTH-1:1]} : data_i;
    bit_o = op_i == OP_LSL ? data_i[WIDTH-1] : op_i == OP_PASS ? 1'b0 : data_i[0];
  end
endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shifter, one bit per clock under a start/done handshake.
// Define SHIFT_SEQ_STICKY_EN to accumulate the OR of all shifted-out bits on sticky.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMTW = DEF_AMTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMTW-1:0]  amt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic             sticky
);
  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [AMTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op_i  (op_q),
    .data_i(dout_q),
    .data_o(step_data),
    .bit_o (step_bit)
  );

  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    dout_d = dout_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: if (start) begin
        dout_d = din;
        op_d = op;
        cnt_d = amt;
        carry_d = 1'b0;
        state_d = (amt == '0 || op == OP_PASS) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        dout_d = step_data;
        carry_d = step_bit;
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == AMTW'(1) ? S_DONE : S_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= OP_PASS;
      cnt_q <= '0;
      dout_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      carry_q <= carry_d;
    end
  end

`ifdef SHIFT_SEQ_STICKY_EN
  logic sticky_q, sticky_d;
  always_comb begin
    sticky_d = sticky_q;
    if (state_q == S_IDLE && start) sticky_d = 1'b0;
    else if (state_q == S_SHIFT) sticky_d = sticky_q | step_bit;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky_q <= 1'b0;
    else sticky_q <= sticky_d;
  end
  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign dout = dout_q;
  assign carry = carry_q;
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: randomized and directed checks of shift_seq against a closed-form shift model.
module tb_shift_seq;
`ifdef SHIFT_SEQ_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [3:0] amt = 4'd0;
  logic [15:0] din = 16'h0;
  logic busy, done, carry, sticky;
  logic [15:0] dout;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  bit m_busy = 1'b0;
  int m_rem = 0;
  logic [15:0] f_dout = 16'h0;
  logic f_carry = 1'b0, f_sticky = 1'b0;

  shift_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .amt(amt), .din(din),
    .busy(busy), .done(done), .dout(dout), .carry(carry), .sticky(sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Final result of shifting d by amount a under op o, from arithmetic on the whole word.
  function automatic void expect_of(input logic [15:0] d, input logic [1:0] o, input int a,
                                    output logic [15:0] r, output logic c, output logic s);
    logic [31:0] w;
    int sd;
    w = {16'h0, d};
    sd = int'($signed(d));
    r = d; c = 1'b0; s = 1'b0;
    if (a != 0 && o != 2'b00) begin
      if (o == 2'b01) begin
        r = 16'(w << a);
        c = w[16 - a];
        s = |(w >> (16 - a));
      end else begin
        r = o == 2'b10 ? 16'(w >> a) : 16'(sd >>> a);
        c = w[a - 1];
        s = |(w & ((32'd1 << a) - 1));
      end
    end
    s = s & STK;
  endfunction

  task automatic model_step();
    logic [15:0] r;
    logic c, s;
    if (reset) begin
      m_busy = 1'b0; m_rem = 0; f_dout = 16'h0; f_carry = 1'b0; f_sticky = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        expect_of(din, op, int'(amt), r, c, s);
        f_dout = r; f_carry = c; f_sticky = s;
        m_busy = 1'b1;
        m_rem = (amt == 4'd0 || op == 2'b00) ? 0 : int'(amt);
      end
    end else if (m_rem == 0) m_busy = 1'b0;
    else m_rem--;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_busy && m_rem == 0));
      if (!m_busy || m_rem == 0) begin
        chk("dout", 32'(dout), 32'(f_dout));
        chk("carry", 32'(carry), 32'(f_carry));
        chk("sticky", 32'(sticky), 32'(f_sticky));
      end
    end
  end

  task automatic run(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a,
                     input logic [15:0] e_d, input logic e_c, input logic e_s,
                     input int e_lat, input bit inject);
    int lat, nb;
    bit got;
    lat = 0; nb = 0; got = 1'b0;
    din = d; op = o; amt = a; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      if (done) begin got = 1'b1; break; end
      if (inject && lat == 2) begin start = 1'b1; din = 16'hFFFF; op = 2'b00; amt = 4'd1; end
      else start = 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(e_lat));
    chk("busy_cycles", 32'(nb), 32'(e_lat + 1));
    chk("res_dout", 32'(dout), 32'(e_d));
    chk("res_carry", 32'(carry), 32'(e_c));
    chk("res_sticky", 32'(sticky), 32'(e_s & STK));
    tick();
    chk("one_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("held_dout", 32'(dout), 32'(e_d));
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    run(16'h8001, 2'b01, 4'd3, 16'h0008, 1'b0, 1'b1, 3, 1'b0);
    run(16'h00F0, 2'b10, 4'd5, 16'h0007, 1'b1, 1'b1, 5, 1'b0);
    run(16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0, 1'b0, 15, 1'b0);
    run(16'h8000, 2'b11, 4'd4, 16'hF800, 1'b0, 1'b0, 4, 1'b0);
    run(16'h1234, 2'b01, 4'd0, 16'h1234, 1'b0, 1'b0, 0, 1'b0);
    run(16'h1234, 2'b00, 4'd9, 16'h1234, 1'b0, 1'b0, 0, 1'b0);
    run(16'h0F0F, 2'b01, 4'd6, 16'hC3C0, 1'b1, 1'b1, 6, 1'b1);
    din = 16'hAAAA; op = 2'b01; amt = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run(16'hAAAA, 2'b01, 4'd1, 16'h5554, 1'b1, 1'b1, 1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 80) == 0;
      start = ($urandom % 3) == 0;
      op = 2'($urandom);
      amt = 4'($urandom);
      din = 16'($urandom);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
